// File: rtl/frame_streamer_pkg.sv
// Shared optical-flow definitions: streamer FSM encoding and frame-buffer read latency.
package frame_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fs_state_e;

  // Cycles from mem_rd_en to the registered pixel outputs.
  localparam int unsigned RD_LATENCY = 2;

endpackage

// File: rtl/frame_streamer.sv
// Streams one frame in raster order from two frame-buffer banks and presents
// the current/previous-frame pixel pair to the gradient stage.
module frame_streamer
  import frame_streamer_pkg::*;
#(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int PIXEL_WIDTH = 8,
  parameter int ADDR_WIDTH  = $clog2(WIDTH * HEIGHT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   swap_banks,
  input  logic                   en,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata_a,
  input  logic [PIXEL_WIDTH-1:0] mem_rdata_b,
  output logic [PIXEL_WIDTH-1:0] pixel_curr,
  output logic [PIXEL_WIDTH-1:0] pixel_prev,
  output logic                   pixel_valid,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   curr_bank,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned           NPIX       = WIDTH * HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [1:0]            DRAIN_LAST = 2'(RD_LATENCY - 1);

  fs_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [1:0]             drain_q, drain_d;
  logic                   bank_q, bank_d;
  logic                   rd_en_s, issue_last_s;
  logic                   rd_q, rd_d;
  logic                   last_q, last_d;
  logic [PIXEL_WIDTH-1:0] curr_q, curr_d, prev_q, prev_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic [15:0]            cnt_q, cnt_d;

  // Control FSM: start/swap handling, address issue and drain sequencing.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    drain_d      = drain_q;
    bank_d       = bank_q;
    rd_en_s      = 1'b0;
    issue_last_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        drain_d = 2'd0;
        // Swap is applied before start so a same-cycle start uses the new bank.
        if (swap_banks) begin
          bank_d = ~bank_q;
        end else begin
          bank_d = bank_q;
        end
        if (start) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (en) begin
          rd_en_s = 1'b1;
          if (addr_q == LAST_ADDR) begin
            issue_last_s = 1'b1;
            addr_d       = {ADDR_WIDTH{1'b0}};
            state_d      = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          drain_d = 2'd0;
          state_d = ST_IDLE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-data pipeline: data arrives one cycle after the strobe and is registered.
  always_comb begin
    rd_d    = rd_en_s;
    last_d  = issue_last_s;
    valid_d = rd_q;
    curr_d  = rd_q ? (bank_q ? mem_rdata_b : mem_rdata_a) : curr_q;
    prev_d  = rd_q ? (bank_q ? mem_rdata_a : mem_rdata_b) : prev_q;
    done_d  = last_q;
    cnt_d   = last_q ? (cnt_q + 16'd1) : cnt_q;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and pipeline registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      drain_q <= 2'd0;
      bank_q  <= 1'b0;
      rd_q    <= 1'b0;
      last_q  <= 1'b0;
      curr_q  <= {PIXEL_WIDTH{1'b0}};
      prev_q  <= {PIXEL_WIDTH{1'b0}};
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
      bank_q  <= bank_d;
      rd_q    <= rd_d;
      last_q  <= last_d;
      curr_q  <= curr_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_rd_en   = rd_en_s;
  assign mem_addr    = addr_q;
  assign pixel_curr  = curr_q;
  assign pixel_prev  = prev_q;
  assign pixel_valid = valid_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign curr_bank   = bank_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Randomized self-checking bench for frame_streamer on a 4x3 frame against a
// schedule-level reference model (issue cycles derived from the en pattern).
module tb_frame_streamer;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int N    = W * H;
  localparam int PW   = 8;
  localparam int AW   = 4;
  localparam int MAXC = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          swap_banks = 1'b0;
  logic          en = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [PW-1:0] mem_rdata_a = 8'd0;
  logic [PW-1:0] mem_rdata_b = 8'd0;
  logic [PW-1:0] pixel_curr, pixel_prev;
  logic          pixel_valid, busy, frame_done, curr_bank;
  logic [15:0]   frame_cnt;

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] bank_a [16];
  logic [PW-1:0] bank_b [16];
  bit            en_pat [MAXC];

  bit            m_bank = 1'b0;
  logic [PW-1:0] m_curr = 8'd0;
  logic [PW-1:0] m_prev = 8'd0;
  logic [15:0]   m_cnt  = 16'd0;

  frame_streamer #(.WIDTH(W), .HEIGHT(H), .PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .swap_banks(swap_banks), .en(en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b),
    .pixel_curr(pixel_curr), .pixel_prev(pixel_prev), .pixel_valid(pixel_valid),
    .busy(busy), .frame_done(frame_done), .curr_bank(curr_bank), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Frame buffers: data one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata_a <= bank_a[mem_addr];
      mem_rdata_b <= bank_b[mem_addr];
    end else begin
      mem_rdata_a <= 8'($urandom);
      mem_rdata_b <= 8'($urandom);
    end
  end

  task automatic fill_banks(input bit ramp);
    for (int i = 0; i < 16; i++) begin
      bank_a[i] = ramp ? 8'(i) : 8'($urandom);
      bank_b[i] = ramp ? 8'(i + 100) : 8'($urandom);
    end
  endtask

  task automatic en_all_ones();
    for (int c = 0; c < MAXC; c++) en_pat[c] = 1'b1;
  endtask

  task automatic en_random();
    for (int c = 0; c < MAXC; c++) en_pat[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
  endtask

  // Runs one frame (start at cycle 0, optional mid-frame start+swap) and checks every cycle.
  task automatic stream_frame(input string tag, input bit swap, input int mid_c);
    int   pix_at [MAXC + 4];
    int   k, ki, last_c, idx;
    bit   old_bank, erd, ebusy, ev, ed, eb;
    logic [AW-1:0] ea;
    for (int c = 0; c < MAXC + 4; c++) pix_at[c] = -1;
    k = 0;
    last_c = -1;
    for (int c = 1; c < MAXC; c++) begin
      if (k < N && en_pat[c]) begin
        pix_at[c + 2] = k;
        if (k == N - 1) last_c = c + 2;
        k++;
      end
    end
    checks++;
    if (last_c < 0) begin
      failures++;
      $display("FAIL %s schedule: issued=%0d required=%0d", tag, k, N);
      return;
    end
    old_bank = m_bank;
    if (swap) m_bank = ~m_bank;
    ki = 0;
    for (int c = 0; c <= last_c + 3; c++) begin
      @(negedge clk);
      start      = (c == 0) || (c == mid_c);
      swap_banks = ((c == 0) && swap) || (c == mid_c);
      en         = en_pat[c < MAXC ? c : MAXC - 1];
      #1;
      erd   = (c >= 1) && (ki < N) && en_pat[c];
      ea    = (ki < N) ? AW'(ki) : 4'd0;
      ebusy = (c >= 1) && (c <= last_c);
      ev    = pix_at[c] >= 0;
      ed    = (c == last_c);
      eb    = (c == 0) ? old_bank : m_bank;
      if (ev) begin
        idx    = pix_at[c];
        m_curr = m_bank ? bank_b[idx] : bank_a[idx];
        m_prev = m_bank ? bank_a[idx] : bank_b[idx];
      end
      if (ed) m_cnt = m_cnt + 16'd1;
      checks += 9;
      if (mem_rd_en !== erd) begin
        failures++; $display("FAIL %s c=%0d mem_rd_en got=%0b exp=%0b", tag, c, mem_rd_en, erd);
      end
      if (mem_addr !== ea) begin
        failures++; $display("FAIL %s c=%0d mem_addr got=%0d exp=%0d", tag, c, mem_addr, ea);
      end
      if (pixel_valid !== ev) begin
        failures++; $display("FAIL %s c=%0d pixel_valid got=%0b exp=%0b", tag, c, pixel_valid, ev);
      end
      if (pixel_curr !== m_curr) begin
        failures++; $display("FAIL %s c=%0d pixel_curr got=%0d exp=%0d", tag, c, pixel_curr, m_curr);
      end
      if (pixel_prev !== m_prev) begin
        failures++; $display("FAIL %s c=%0d pixel_prev got=%0d exp=%0d", tag, c, pixel_prev, m_prev);
      end
      if (frame_done !== ed) begin
        failures++; $display("FAIL %s c=%0d frame_done got=%0b exp=%0b", tag, c, frame_done, ed);
      end
      if (busy !== ebusy) begin
        failures++; $display("FAIL %s c=%0d busy got=%0b exp=%0b", tag, c, busy, ebusy);
      end
      if (curr_bank !== eb) begin
        failures++; $display("FAIL %s c=%0d curr_bank got=%0b exp=%0b", tag, c, curr_bank, eb);
      end
      if (frame_cnt !== m_cnt) begin
        failures++; $display("FAIL %s c=%0d frame_cnt got=%0h exp=%0h", tag, c, frame_cnt, m_cnt);
      end
      if (erd) ki++;
    end
    start = 1'b0;
    swap_banks = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_rd_en, mem_addr, pixel_curr, pixel_prev, pixel_valid, busy, frame_done, curr_bank, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_state got rd=%0b addr=%0d cur=%0d prv=%0d v=%0b busy=%0b done=%0b bank=%0b cnt=%0h exp all zero",
               mem_rd_en, mem_addr, pixel_curr, pixel_prev, pixel_valid, busy, frame_done, curr_bank, frame_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    fill_banks(1'b1);
    en_all_ones();
    stream_frame("basic", 1'b0, -1);
  endtask

  task automatic test_swap();
    fill_banks(1'b1);
    en_all_ones();
    stream_frame("swap", 1'b1, -1);
  endtask

  task automatic test_en_gaps();
    fill_banks(1'b0);
    en_all_ones();
    en_pat[2] = 1'b0;
    en_pat[3] = 1'b0;
    stream_frame("en_gaps", 1'b0, -1);
  endtask

  task automatic test_mid_frame_ignore();
    fill_banks(1'b0);
    en_all_ones();
    stream_frame("mid_ignore", 1'b0, 5);
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      fill_banks(1'b0);
      en_random();
      stream_frame("random", 1'($urandom_range(0, 1)), (f == 2) ? 6 : -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      fill_banks(1'b0);
      en_all_ones();
      stream_frame("back_to_back", 1'(f), -1);
    end
  endtask

  task automatic test_reset_abort();
    fill_banks(1'b0);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      start      = (c == 0);
      swap_banks = (c == 0) && (m_bank == 1'b0);
      en         = 1'b1;
    end
    start = 1'b0;
    swap_banks = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_rd_en, mem_addr, pixel_curr, pixel_prev, pixel_valid, busy, frame_done, curr_bank, frame_cnt} !== '0) begin
      failures++;
      $display("FAIL abort_state got rd=%0b addr=%0d cur=%0d prv=%0d v=%0b busy=%0b done=%0b bank=%0b cnt=%0h exp all zero",
               mem_rd_en, mem_addr, pixel_curr, pixel_prev, pixel_valid, busy, frame_done, curr_bank, frame_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_bank = 1'b0;
    m_curr = 8'd0;
    m_prev = 8'd0;
    m_cnt  = 16'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (pixel_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet c=%0d got v=%0b done=%0b busy=%0b exp 0", c, pixel_valid, frame_done, busy);
      end
    end
    fill_banks(1'b0);
    en_all_ones();
    stream_frame("after_abort", 1'b0, -1);
  endtask

  task automatic test_frame_cnt_wrap();
    @(negedge clk);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    #1;
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_preload got=%0h exp=ffff", frame_cnt);
    end
    m_cnt = 16'hFFFF;
    fill_banks(1'b0);
    en_all_ones();
    stream_frame("cnt_wrap", 1'b0, -1);
    checks++;
    if (frame_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL cnt_wrap_final got=%0h exp=0", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_swap();
    test_en_gaps();
    test_mid_frame_ignore();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_frame_cnt_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 320, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 240, frame height in lines.
REQ-003 SHALL have parameter PIXEL_WIDTH, default 8, pixel bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default $clog2(WIDTH*HEIGHT), buffer address bits.
REQ-005 clk  input  1  single clock; all logic on posedge; one clock, no other clock domains.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle pulse requesting one frame stream.
REQ-008 swap_banks  input  1  one-cycle pulse toggling current/previous bank roles.
REQ-009 en  input  1  flow enable; low pauses address issue.
REQ-010 mem_rd_en  output  1  read strobe to both frame buffers.
REQ-011 mem_addr  output  ADDR_WIDTH  raster address, shared by both buffers.
REQ-012 mem_rdata_a / mem_rdata_b  input  PIXEL_WIDTH each  bank A/B read data, valid 1 cycle after mem_rd_en.
REQ-013 pixel_curr / pixel_prev  output  PIXEL_WIDTH each  registered current/previous-frame pixel.
REQ-014 pixel_valid  output  1  qualifies pixel_curr/pixel_prev.
REQ-015 busy  output  1  high from accepted start until the cycle after frame_done.
REQ-016 frame_done  output  1  one-cycle pulse with the last pixel_valid of a frame.
REQ-017 curr_bank  output  1  0: bank A is current; 1: bank B is current.
REQ-018 frame_cnt  output  16  completed-frame count, wraps 0xFFFF->0.

Function
REQ-019 FSM states SHALL be IDLE, READ, DRAIN.
REQ-020 IDLE->READ on start; start while in READ/DRAIN SHALL be ignored.
REQ-021 In READ, each cycle with en=1 SHALL assert mem_rd_en and issue mem_addr, incrementing 0..WIDTH*HEIGHT-1 in raster order.
REQ-022 In READ with en=0, mem_rd_en SHALL be 0 and mem_addr SHALL hold.
REQ-023 Issue of address WIDTH*HEIGHT-1 SHALL move READ->DRAIN; address counter SHALL return to 0.
REQ-024 Latency SHALL be 2 cycles: mem_rd_en at cycle t -> pixel_valid=1 at t+2 with that address's data.
REQ-025 pixel_curr SHALL take the curr_bank bank's data and pixel_prev the other bank's data.
REQ-026 DRAIN SHALL last 2 cycles, then go to IDLE; in-flight reads SHALL always be emitted regardless of en.
REQ-027 frame_done SHALL pulse coincident with the pixel_valid of address WIDTH*HEIGHT-1; frame_cnt SHALL increment in the same cycle.
REQ-028 Exactly WIDTH*HEIGHT pixel_valid cycles SHALL occur per frame.
REQ-029 swap_banks SHALL toggle curr_bank only in IDLE; it SHALL be ignored in READ/DRAIN.
REQ-030 start and swap_banks in the same IDLE cycle: the swap SHALL take effect first; the new frame uses the toggled bank.
REQ-031 pixel_curr/pixel_prev SHALL hold their last value when pixel_valid=0.

Reset
REQ-032 On rst_n low, state SHALL go to IDLE and mem_rd_en, mem_addr, pixel_curr, pixel_prev, pixel_valid, busy, frame_done, curr_bank and frame_cnt SHALL all be 0.
REQ-033 Reset mid-frame SHALL abort immediately; no pixel_valid or frame_done SHALL follow for the aborted frame.

Structure
REQ-034 The FSM state enum and the 2-cycle read-latency constant SHALL live in the shared optical-flow package.
REQ-035 SHALL be a single module with no sub-modules; the output side directly drives gradient_compute pixel_curr/pixel_prev/pixel_valid.

Verification
REQ-036 WIDTH=4, HEIGHT=3, en=1, start at cycle 0 -> 12 consecutive pixel_valid from cycle 3, frame_done with the 12th, busy low after it.
REQ-037 Bank A data=addr, bank B data=addr+100, curr_bank=0 -> pixel_curr=0..11 and pixel_prev=100..111; after swap_banks -> values reversed.
REQ-038 en toggled 1,0,0,1 during READ -> pixel_valid has matching 2-cycle gaps delayed by 2, 12 pixels total, data order unchanged.
REQ-039 start and swap_banks pulsed mid-frame -> ignored, curr_bank unchanged, frame completes normally.
REQ-040 rst_n asserted at pixel 5 -> all outputs 0, no frame_done; new start streams a full 12-pixel frame from address 0.
REQ-041 frame_cnt preloaded to 0xFFFF by streaming (forced) -> next frame_done wraps frame_cnt to 0.
